// File: rtl/falco_mem_arbiter.sv
// Round-robin arbiter sharing one single-outstanding memory port between fetch, load and store.
// One transaction in flight at a time; a response that never arrives completes with an error.
module falco_mem_arbiter #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              if_req_valid,
    input  logic [ADDR_W-1:0] if_req_addr,
    output logic              if_req_ready,

    input  logic              ld_req_valid,
    input  logic [ADDR_W-1:0] ld_req_addr,
    output logic              ld_req_ready,

    input  logic              st_req_valid,
    input  logic [ADDR_W-1:0] st_req_addr,
    input  logic [DATA_W-1:0] st_req_wdata,
    output logic              st_req_ready,

    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_req_we,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic [DATA_W-1:0] mem_req_wdata,
    input  logic              mem_resp_valid,
    input  logic [DATA_W-1:0] mem_resp_rdata,

    output logic              if_resp_valid,
    output logic              ld_resp_valid,
    output logic              st_resp_valid,
    output logic [DATA_W-1:0] resp_data,
    output logic              resp_err,
    output logic              err_sticky
);

    // Timer counts 0 .. TIMEOUT-1 while waiting for the memory response.
    localparam int unsigned TimerW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TimerW-1:0] TimerLast = TimerW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait,
        StResp
    } state_e;

    typedef enum logic [1:0] {
        SrcIf = 2'd0,
        SrcLd = 2'd1,
        SrcSt = 2'd2
    } src_e;

    function automatic src_e next_src(input src_e s);
        case (s)
            SrcIf:   return SrcLd;
            SrcLd:   return SrcSt;
            default: return SrcIf;
        endcase
    endfunction

    state_e              state_q, state_d;
    src_e                rr_ptr_q, rr_ptr_d;
    src_e                src_q, src_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [TimerW-1:0]   timer_q, timer_d;
    logic [DATA_W-1:0]   resp_data_q, resp_data_d;
    logic                resp_err_q, resp_err_d;
    logic                err_sticky_q, err_sticky_d;

    logic [3:0]          req_vec;
    logic [2:0]          rr_idx;
    logic                grant_valid;
    src_e                grant_src;

    // First valid requester at or after the round-robin pointer.
    always_comb begin
        req_vec     = {1'b0, st_req_valid, ld_req_valid, if_req_valid};
        rr_idx      = '0;
        grant_valid = 1'b0;
        grant_src   = SrcIf;
        for (int k = 0; k < 3; k++) begin
            rr_idx = {1'b0, rr_ptr_q} + 3'(k);
            if (rr_idx >= 3'd3) begin
                rr_idx = rr_idx - 3'd3;
            end
            if (!grant_valid && req_vec[rr_idx[1:0]]) begin
                grant_valid = 1'b1;
                grant_src   = src_e'(rr_idx[1:0]);
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        src_d        = src_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        timer_d      = timer_q;
        resp_data_d  = resp_data_q;
        resp_err_d   = resp_err_q;
        err_sticky_d = err_sticky_q;

        unique case (state_q)
            StIdle: begin
                if (grant_valid) begin
                    state_d     = StIssue;
                    src_d       = grant_src;
                    rr_ptr_d    = next_src(grant_src);
                    we_d        = (grant_src == SrcSt);
                    resp_data_d = '0;
                    resp_err_d  = 1'b0;
                    unique case (grant_src)
                        SrcIf: begin
                            addr_d  = if_req_addr;
                            wdata_d = '0;
                        end
                        SrcLd: begin
                            addr_d  = ld_req_addr;
                            wdata_d = '0;
                        end
                        default: begin
                            addr_d  = st_req_addr;
                            wdata_d = st_req_wdata;
                        end
                    endcase
                end
            end
            StIssue: begin
                if (mem_req_ready) begin
                    state_d = StWait;
                    timer_d = '0;
                end
            end
            StWait: begin
                if (mem_resp_valid) begin
                    state_d     = StResp;
                    resp_data_d = we_q ? '0 : mem_resp_rdata;
                    resp_err_d  = 1'b0;
                end else if (timer_q == TimerLast) begin
                    state_d      = StResp;
                    resp_data_d  = '0;
                    resp_err_d   = 1'b1;
                    err_sticky_d = 1'b1;
                end else begin
                    timer_d = timer_q + TimerW'(1);
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            rr_ptr_q     <= SrcIf;
            src_q        <= SrcIf;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            timer_q      <= '0;
            resp_data_q  <= '0;
            resp_err_q   <= 1'b0;
            err_sticky_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            src_q        <= src_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            timer_q      <= timer_d;
            resp_data_q  <= resp_data_d;
            resp_err_q   <= resp_err_d;
            err_sticky_q <= err_sticky_d;
        end
    end

    // Handshake outputs are forced low while rst is asserted, whatever the current state.
    logic idle_grant;
    logic in_resp;

    assign idle_grant = !rst && (state_q == StIdle) && grant_valid;
    assign in_resp    = !rst && (state_q == StResp);

    assign if_req_ready  = idle_grant && (grant_src == SrcIf);
    assign ld_req_ready  = idle_grant && (grant_src == SrcLd);
    assign st_req_ready  = idle_grant && (grant_src == SrcSt);

    assign mem_req_valid = !rst && (state_q == StIssue);
    assign mem_req_we    = we_q;
    assign mem_req_addr  = addr_q;
    assign mem_req_wdata = wdata_q;

    assign if_resp_valid = in_resp && (src_q == SrcIf);
    assign ld_resp_valid = in_resp && (src_q == SrcLd);
    assign st_resp_valid = in_resp && (src_q == SrcSt);
    assign resp_data     = in_resp ? resp_data_q : '0;
    assign resp_err      = in_resp && resp_err_q;
    assign err_sticky    = err_sticky_q;

endmodule

// File: tb/tb_falco_mem_arbiter.sv
// Bench for falco_mem_arbiter: directed scenarios followed by random traffic, all checked against a
// transaction-level model of grant order, request fields, response timing and error reporting.
module tb_falco_mem_arbiter;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req_valid, ld_req_valid, st_req_valid;
    logic [31:0] if_req_addr, ld_req_addr, st_req_addr, st_req_wdata;
    logic        if_req_ready, ld_req_ready, st_req_ready;
    logic        mem_req_valid, mem_req_ready, mem_req_we;
    logic [31:0] mem_req_addr, mem_req_wdata;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_rdata;
    logic        if_resp_valid, ld_resp_valid, st_resp_valid;
    logic [31:0] resp_data;
    logic        resp_err, err_sticky;

    always #5 clk = ~clk;

    falco_mem_arbiter #(
        .ADDR_W (32),
        .DATA_W (32),
        .TIMEOUT(TO)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .if_req_valid  (if_req_valid),
        .if_req_addr   (if_req_addr),
        .if_req_ready  (if_req_ready),
        .ld_req_valid  (ld_req_valid),
        .ld_req_addr   (ld_req_addr),
        .ld_req_ready  (ld_req_ready),
        .st_req_valid  (st_req_valid),
        .st_req_addr   (st_req_addr),
        .st_req_wdata  (st_req_wdata),
        .st_req_ready  (st_req_ready),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_req_we    (mem_req_we),
        .mem_req_addr  (mem_req_addr),
        .mem_req_wdata (mem_req_wdata),
        .mem_resp_valid(mem_resp_valid),
        .mem_resp_rdata(mem_resp_rdata),
        .if_resp_valid (if_resp_valid),
        .ld_resp_valid (ld_resp_valid),
        .st_resp_valid (st_resp_valid),
        .resp_data     (resp_data),
        .resp_err      (resp_err),
        .err_sticky    (err_sticky)
    );

    int n_asserts = 0;
    int n_fail    = 0;
    int cyc       = 0;

    // Transaction-level model: idle/busy, issue phase, waiting phase, one pending response.
    bit          busy, issuing, inflight, pend, sticky;
    int          ptr;
    int          exp_src;
    logic        exp_we;
    logic [31:0] exp_addr, exp_wdata, exp_data, mem_rdata_plan;
    bit          exp_err;
    int          resp_in_cyc, resp_out_cyc, inflight_end;

    // Stimulus knobs.
    bit          hold_mode, rand_mode, plan_never;
    int          raise_prob, stall_cnt, stall_prob, spur_prob, plan_dly;
    logic [31:0] plan_rdata;
    bit          req_v[3];
    logic [31:0] req_a[3];
    logic [31:0] st_wd;

    // Observation log taken from the DUT outputs.
    int          grant_log[$];
    int          resp_count, last_ready_cyc, last_resp_cyc, last_resp_src;
    logic [31:0] last_resp_data;
    logic        last_resp_err;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
        end
    endtask

    task automatic cycle();
        logic        drv_resp, drv_mready;
        logic [31:0] drv_rdata;
        int          g;
        bit          exp_pulse, sticky_vis;

        if (raise_prob > 0) begin
            for (int i = 0; i < 3; i++) begin
                if (!req_v[i] && $urandom_range(99) < raise_prob) begin
                    req_v[i] = 1'b1;
                    req_a[i] = $urandom;
                    if (i == 2) st_wd = $urandom;
                end
            end
        end

        drv_resp  = 1'b0;
        drv_rdata = $urandom;
        if (inflight && cyc == resp_in_cyc) begin
            drv_resp  = 1'b1;
            drv_rdata = mem_rdata_plan;
        end else if (!inflight && $urandom_range(99) < spur_prob) begin
            drv_resp = 1'b1;
        end

        if (issuing && stall_cnt > 0) begin
            drv_mready = 1'b0;
            stall_cnt--;
        end else if (issuing) begin
            drv_mready = ($urandom_range(99) >= stall_prob);
        end else begin
            drv_mready = 1'($urandom_range(1));
        end

        if_req_valid   = req_v[0];
        if_req_addr    = req_a[0];
        ld_req_valid   = req_v[1];
        ld_req_addr    = req_a[1];
        st_req_valid   = req_v[2];
        st_req_addr    = req_a[2];
        st_req_wdata   = st_wd;
        mem_req_ready  = drv_mready;
        mem_resp_valid = drv_resp;
        mem_resp_rdata = drv_rdata;
        #1;

        g = -1;
        if (!rst && !busy) begin
            for (int k = 0; k < 3; k++) begin
                if (g < 0 && req_v[(ptr + k) % 3]) g = (ptr + k) % 3;
            end
        end
        chk("if_req_ready", 32'(if_req_ready), 32'(g == 0));
        chk("ld_req_ready", 32'(ld_req_ready), 32'(g == 1));
        chk("st_req_ready", 32'(st_req_ready), 32'(g == 2));

        chk("mem_req_valid", 32'(mem_req_valid), 32'(issuing && !rst));
        if (issuing && !rst) begin
            chk("mem_req_we", 32'(mem_req_we), 32'(exp_we));
            chk("mem_req_addr", mem_req_addr, exp_addr);
            chk("mem_req_wdata", mem_req_wdata, exp_wdata);
        end

        exp_pulse = pend && !rst && (cyc == resp_out_cyc);
        chk("if_resp_valid", 32'(if_resp_valid), 32'(exp_pulse && exp_src == 0));
        chk("ld_resp_valid", 32'(ld_resp_valid), 32'(exp_pulse && exp_src == 1));
        chk("st_resp_valid", 32'(st_resp_valid), 32'(exp_pulse && exp_src == 2));
        if (exp_pulse) begin
            chk("resp_data", resp_data, exp_data);
            chk("resp_err", 32'(resp_err), 32'(exp_err));
        end
        sticky_vis = sticky || (pend && cyc == resp_out_cyc && exp_err);
        chk("err_sticky", 32'(err_sticky), 32'(sticky_vis));

        if (if_req_ready) grant_log.push_back(0);
        if (ld_req_ready) grant_log.push_back(1);
        if (st_req_ready) grant_log.push_back(2);
        if (if_req_ready || ld_req_ready || st_req_ready) last_ready_cyc = cyc;
        if (if_resp_valid || ld_resp_valid || st_resp_valid) begin
            resp_count++;
            last_resp_cyc  = cyc;
            last_resp_data = resp_data;
            last_resp_err  = resp_err;
            last_resp_src  = if_resp_valid ? 0 : (ld_resp_valid ? 1 : 2);
        end

        if (rst) begin
            busy     = 1'b0;
            issuing  = 1'b0;
            inflight = 1'b0;
            pend     = 1'b0;
            sticky   = 1'b0;
            ptr      = 0;
        end else begin
            sticky = sticky_vis;
            if (pend && cyc == resp_out_cyc) begin
                pend = 1'b0;
                busy = 1'b0;
            end
            if (inflight && cyc == inflight_end) inflight = 1'b0;
            if (issuing && drv_mready) begin
                issuing = 1'b0;
                if (rand_mode) begin
                    plan_never = ($urandom_range(99) < 15);
                    plan_dly   = $urandom_range(3, 1);
                    plan_rdata = $urandom;
                end
                inflight = 1'b1;
                pend     = 1'b1;
                if (plan_never) begin
                    resp_in_cyc  = -1;
                    inflight_end = cyc + TO;
                    resp_out_cyc = cyc + TO + 1;
                    exp_err      = 1'b1;
                    exp_data     = '0;
                end else begin
                    resp_in_cyc    = cyc + plan_dly;
                    inflight_end   = resp_in_cyc;
                    resp_out_cyc   = resp_in_cyc + 1;
                    mem_rdata_plan = plan_rdata;
                    exp_err        = 1'b0;
                    exp_data       = exp_we ? 32'h0 : plan_rdata;
                end
            end
            if (g >= 0) begin
                busy      = 1'b1;
                issuing   = 1'b1;
                exp_src   = g;
                exp_we    = (g == 2);
                exp_addr  = req_a[g];
                exp_wdata = (g == 2) ? st_wd : 32'h0;
                ptr       = (g + 1) % 3;
                if (hold_mode) begin
                    req_a[g] = req_a[g] + 32'h10;
                    if (g == 2) st_wd = st_wd + 32'h1;
                end else begin
                    req_v[g] = 1'b0;
                end
            end
        end

        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    initial begin
        int exp_order[4];
        exp_order = '{0, 1, 2, 0};

        rst = 1'b1;
        {busy, issuing, inflight, pend, sticky} = '0;
        ptr = 0;
        hold_mode = 1'b0; rand_mode = 1'b0; plan_never = 1'b0;
        raise_prob = 0; stall_cnt = 0; stall_prob = 0; spur_prob = 0;
        plan_dly = 1; plan_rdata = 32'h1234_5678;
        req_v[0] = 1'b1; req_v[1] = 1'b1; req_v[2] = 1'b1;
        req_a[0] = 32'h0000_1000; req_a[1] = 32'h0000_2000; req_a[2] = 32'h0000_3000;
        st_wd = 32'hCAFE_0001;
        resp_count = 0; last_ready_cyc = 0; last_resp_cyc = 0; last_resp_src = -1;
        last_resp_data = '0; last_resp_err = 1'b0;
        if_req_valid = 1'b1; ld_req_valid = 1'b1; st_req_valid = 1'b1;
        if_req_addr = '0; ld_req_addr = '0; st_req_addr = '0; st_req_wdata = '0;
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_rdata = '0;
        @(posedge clk);
        @(negedge clk);

        // Reset held with every requester valid: nothing may be granted or issued.
        repeat (2) cycle();

        // All three held valid: round-robin IF, LD, ST, IF; store carries we and wdata.
        rst = 1'b0;
        hold_mode = 1'b1;
        grant_log.delete();
        repeat (16) cycle();
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("rr_order_%0d", i),
                (i < grant_log.size()) ? 32'(grant_log[i]) : 32'hFFFF_FFFF, 32'(exp_order[i]));
        end
        hold_mode = 1'b0;
        req_v[0] = 1'b0; req_v[1] = 1'b0; req_v[2] = 1'b0;
        repeat (6) cycle();

        // Single fetch with minimum latency.
        req_v[0] = 1'b1; req_a[0] = 32'h0000_0100;
        plan_dly = 1; plan_rdata = 32'hDEAD_BEEF; resp_count = 0;
        repeat (6) cycle();
        chk("fetch_resp_count", 32'(resp_count), 32'd1);
        chk("fetch_latency", 32'(last_resp_cyc - last_ready_cyc), 32'd3);
        chk("fetch_data", last_resp_data, 32'hDEAD_BEEF);
        chk("fetch_src", 32'(last_resp_src), 32'd0);

        // Memory stalls the request for five cycles.
        req_v[1] = 1'b1; req_a[1] = 32'h2222_0000;
        stall_cnt = 5; plan_rdata = 32'h0BAD_F00D; resp_count = 0;
        repeat (12) cycle();
        chk("stall_latency", 32'(last_resp_cyc - last_ready_cyc), 32'd8);
        chk("stall_data", last_resp_data, 32'h0BAD_F00D);

        // Load that never gets a response; stray responses are driven throughout.
        req_v[1] = 1'b1; req_a[1] = 32'h4444_0000;
        plan_never = 1'b1; spur_prob = 100; resp_count = 0;
        repeat (12) cycle();
        chk("timeout_resp_count", 32'(resp_count), 32'd1);
        chk("timeout_src", 32'(last_resp_src), 32'd1);
        chk("timeout_err", 32'(last_resp_err), 32'd1);
        chk("timeout_data", last_resp_data, 32'h0);
        chk("timeout_latency", 32'(last_resp_cyc - last_ready_cyc), 32'(TO + 2));
        chk("timeout_sticky", 32'(err_sticky), 32'd1);
        plan_never = 1'b0; spur_prob = 0;

        // Reset while waiting for the memory: the store is dropped silently.
        req_v[2] = 1'b1; req_a[2] = 32'h6666_0000; st_wd = 32'h5A5A_5A5A;
        plan_dly = 3; resp_count = 0;
        for (int i = 0; i < 10 && !inflight; i++) cycle();
        chk("rst_reached_wait", 32'(inflight), 32'd1);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        repeat (4) cycle();
        chk("rst_no_resp", 32'(resp_count), 32'd0);
        chk("rst_sticky_clear", 32'(err_sticky), 32'd0);
        req_v[0] = 1'b1; req_a[0] = 32'h0000_0700;
        plan_dly = 2; plan_rdata = 32'h7777_1234;
        repeat (7) cycle();
        chk("post_rst_resp_count", 32'(resp_count), 32'd1);
        chk("post_rst_src", 32'(last_resp_src), 32'd0);
        chk("post_rst_data", last_resp_data, 32'h7777_1234);

        // Random traffic with stalls, timeouts, stray responses and occasional resets.
        rand_mode = 1'b1; raise_prob = 30; stall_prob = 30; spur_prob = 20;
        for (int i = 0; i < 2000; i++) begin
            rst = ($urandom_range(299) == 0);
            cycle();
        end
        rst = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
